elevator_request_queue: RTL and testbench
=========================================

# elevator_request_queue

Producer side of the elevator call path: captures hall/cab button presses and encoded floor requests into a registered pending-floor vector (`queue_status`) that feeds `elevator_direction_resolver`, and clears floors as the cab arrives. It owns the only copy of the request state, synchronizes and edge-detects raw button inputs, and reports pending count, empty status and per-arrival service acknowledgement.

## Interface
- `NUM_FLOORS`, 7, number of floors; one `queue_status` bit per floor, floor 0 = bit 0.
- `FLOOR_W`, 3, width of encoded floor fields; must satisfy 2^FLOOR_W > NUM_FLOORS.
- `DEBOUNCE_CYCLES`, 4, stable cycles required per button edge (used only with `REQ_DEBOUNCE_EN`).
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn`  in  NUM_FLOORS  raw asynchronous floor buttons, active high.
- `req_valid`  in  1  encoded request strobe.
- `req_floor`  in  FLOOR_W  requested floor.
- `req_ready`  out  1  request port ready.
- `req_err`  out  1  one-cycle pulse: accepted request had `req_floor >= NUM_FLOORS`.
- `arrive_valid`  in  1  cab stopped at `arrive_floor` with doors opening.
- `arrive_floor`  in  FLOOR_W  arrival floor.
- `service_ack`  out  1  one-cycle pulse: arrival cleared a pending bit.
- `queue_status`  out  NUM_FLOORS  registered pending-floor vector.
- `queue_empty`  out  1  `queue_status == 0`.
- `req_count`  out  FLOOR_W  popcount of `queue_status`, registered.

## Operation
- Button path: 2-flop synchronizer per bit, then rising-edge detect (sync2 & ~prev). Each detected edge sets its floor bit. A held button produces one edge only.
- Request port: handshake when `req_valid && req_ready`; `req_ready` is 0 during reset and the cycle after reset deasserts, 1 otherwise. A valid floor sets its bit; an out-of-range floor sets nothing and pulses `req_err`. Requests for already-pending floors are accepted with no change.
- Arrival: `arrive_valid` with in-range floor clears that bit; `service_ack` pulses iff the bit was set before the edge. Out-of-range arrival is ignored (no ack, no error).
- Next state per bit: `next = (cur | set) & ~clr`; clear wins over any simultaneous set of the same floor (press while the cab is at the floor with doors opening is served immediately). Button and port sets on the same floor in one cycle merge into one set.
- `req_count` and `queue_empty` are computed from the next-state vector and registered alongside it, so all three outputs stay mutually consistent every cycle.
- Reset: `queue_status`=0, `req_count`=0, `queue_empty`=1, `req_ready`=0, `req_err`=0, `service_ack`=0; synchronizer, edge and debounce state cleared (synchronizer flops reset to 0, so a button held through reset yields one edge after release of reset). Reset mid-operation drops all pending requests.

## Timing
- Port request -> `queue_status` bit: 1 cycle (visible after the accepting edge); `req_err` asserted in the same cycle.
- Button (no debounce) -> bit set: visible after the 3rd rising edge with `btn` high.
- Arrival -> bit cleared and `service_ack` high: 1 cycle, both registered on the same edge.
- `req_count`/`queue_empty` update on the same edge as `queue_status`.
- Throughput: one port request and one arrival per cycle, plus any number of button edges.

## Configuration
- `REQ_DEBOUNCE_EN` defined: per-bit counter after the synchronizer; debounced level changes only after sync2 differs from it for `DEBOUNCE_CYCLES` consecutive cycles; edge detect runs on the debounced level. Button latency becomes 3 + `DEBOUNCE_CYCLES` cycles; glitches shorter than `DEBOUNCE_CYCLES` are ignored.
- Undefined: no counters; edge detect on sync2 directly; `DEBOUNCE_CYCLES` unused.

## Test plan
- Reset: after reset release, `queue_status`=0, `queue_empty`=1, `req_count`=0, `req_ready`=0 for one cycle then 1.
- Port requests floors 4, 1, 6 on consecutive cycles -> `queue_status`=7'b1010010, `req_count`=3, `queue_empty`=0; request floor 7 -> `req_err` pulse, vector unchanged.
- `btn[2]` held 10 cycles -> bit 2 set exactly once, 3 cycles after first sampled high (3+4 with `REQ_DEBOUNCE_EN`); with the macro, a 2-cycle glitch on `btn[5]` sets nothing.
- Arrival at floor 4 with bit set -> bit cleared, `service_ack` 1 cycle, `req_count` decrements; arrival at floor 0 (not pending) -> no ack.
- Same cycle: `req_floor`=3 valid and `arrive_floor`=3 valid -> bit 3 stays 0, `service_ack` follows prior bit 3 state.
- Reset asserted with 7'b1111111 pending -> next cycle all outputs at reset values; no `service_ack` or `req_err`.

Source files
------------

// File: rtl/elevator_request_queue.sv
// elevator_request_queue: pending-floor register for the elevator call path.
// Button presses (synchronized, edge-detected) and encoded port requests set
// floor bits; cab arrivals clear them. Clear wins over a same-cycle set.
// Optional macro REQ_DEBOUNCE_EN: per-button debounce counter between the
// synchronizer and the edge detector.

// Per-floor button lane: 2-flop synchronizer, optional debounce, rising edge.
module erq_btn_lane #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic edge_o
);
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic sync1_q, sync2_q, prev_q;
  logic lvl;

`ifdef REQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          deb_q, deb_d;

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreements.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q;
      else                                   cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign lvl = deb_q;
`else
  assign lvl = sync2_q;
`endif

  // Synchronizer and previous-level flop; reset to 0 so a held button
  // produces one edge after reset releases.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= lvl;
    end
  end

  assign edge_o = lvl & ~prev_q;
endmodule

module elevator_request_queue #(
  parameter int NUM_FLOORS      = 7,
  parameter int FLOOR_W         = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NUM_FLOORS-1:0] btn_i,
  input  logic                  req_valid_i,
  input  logic [FLOOR_W-1:0]    req_floor_i,
  output logic                  req_ready_o,
  output logic                  req_err_o,
  input  logic                  arrive_valid_i,
  input  logic [FLOOR_W-1:0]    arrive_floor_i,
  output logic                  service_ack_o,
  output logic [NUM_FLOORS-1:0] queue_status_o,
  output logic                  queue_empty_o,
  output logic [FLOOR_W-1:0]    req_count_o
);
  if ((1 << FLOOR_W) <= NUM_FLOORS) begin : g_bad_w
    $error("FLOOR_W too narrow for NUM_FLOORS");
  end

  logic [NUM_FLOORS-1:0] btn_edge, set_vec, clr_vec;
  logic [NUM_FLOORS-1:0] status_q, status_d;
  logic [FLOOR_W-1:0]    count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  ready_q, err_q, err_d, ack_q, ack_d;
  logic                  req_acc;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_lane
    erq_btn_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .btn_i  (btn_i[g]),
      .edge_o (btn_edge[g])
    );
  end

  assign req_acc = req_valid_i & ready_q;

  // Decode sets/clears, form next vector and its derived count/empty flags.
  // Out-of-range floors match no bit, so they neither set nor clear.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      set_vec[i] = btn_edge[i] | (req_acc && (req_floor_i == FLOOR_W'(i)));
      clr_vec[i] = arrive_valid_i && (arrive_floor_i == FLOOR_W'(i));
    end
    status_d = (status_q | set_vec) & ~clr_vec;
    count_d  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      count_d = count_d + FLOOR_W'(status_d[i]);
    end
    empty_d = (status_d == '0);
    ack_d   = |(clr_vec & status_q);
    err_d   = req_acc && (req_floor_i >= FLOOR_W'(NUM_FLOORS));
  end

  // State and output registers; ready rises one cycle after reset drops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      status_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      ready_q  <= 1'b1;
      err_q    <= err_d;
      ack_q    <= ack_d;
    end
  end

  assign req_ready_o    = ready_q;
  assign req_err_o      = err_q;
  assign service_ack_o  = ack_q;
  assign queue_status_o = status_q;
  assign queue_empty_o  = empty_q;
  assign req_count_o    = count_q;
endmodule

// File: tb/tb_elevator_request_queue.sv
// Bench for elevator_request_queue: floor-level behavioural model checked
// every cycle, plus hand-computed literal expectations from the test plan.
// Honours REQ_DEBOUNCE_EN the same way as the design.
module tb_elevator_request_queue;
  localparam int NF = 7;
  localparam int FW = 3;
  localparam int DC = 4;
`ifdef REQ_DEBOUNCE_EN
  localparam int BTN_LAT = 3 + DC;
`else
  localparam int BTN_LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] btn = '0;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic          arrive_valid = 1'b0;
  logic [FW-1:0] arrive_floor = '0;
  logic          req_ready, req_err, service_ack, queue_empty;
  logic [NF-1:0] queue_status;
  logic [FW-1:0] req_count;

  always #5 clk = ~clk;

  elevator_request_queue #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DEBOUNCE_CYCLES(DC)) dut (
    .clk_i(clk), .reset_i(reset), .btn_i(btn),
    .req_valid_i(req_valid), .req_floor_i(req_floor), .req_ready_o(req_ready),
    .req_err_o(req_err), .arrive_valid_i(arrive_valid), .arrive_floor_i(arrive_floor),
    .service_ack_o(service_ack), .queue_status_o(queue_status),
    .queue_empty_o(queue_empty), .req_count_o(req_count)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: pending flags per floor, button sample history, pulses.
  bit m_pend[NF];
  bit m_ready, m_err, m_ack;
  bit h1[NF], h2[NF], h3[NF];
`ifdef REQ_DEBOUNCE_EN
  bit lvl[NF], plvl[NF];
  int streak[NF];
`endif
  bit acc, rise, sreq, sclr;

  always @(posedge clk) begin
    if (reset) begin
      m_ready = 0; m_err = 0; m_ack = 0;
      for (int f = 0; f < NF; f++) begin
        m_pend[f] = 0; h1[f] = 0; h2[f] = 0; h3[f] = 0;
`ifdef REQ_DEBOUNCE_EN
        lvl[f] = 0; plvl[f] = 0; streak[f] = 0;
`endif
      end
    end else begin
      acc   = req_valid && m_ready;
      m_err = acc && (int'(req_floor) >= NF);
      m_ack = 0;
      for (int f = 0; f < NF; f++) begin
        // A button edge reaches the queue two samples after it was seen.
`ifdef REQ_DEBOUNCE_EN
        rise    = lvl[f] && !plvl[f];
        plvl[f] = lvl[f];
        if (h2[f] != lvl[f]) begin
          streak[f]++;
          if (streak[f] == DC) begin lvl[f] = h2[f]; streak[f] = 0; end
        end else streak[f] = 0;
`else
        rise = h2[f] && !h3[f];
`endif
        h3[f] = h2[f]; h2[f] = h1[f]; h1[f] = btn[f];
        sreq = acc && (int'(req_floor) == f);
        sclr = arrive_valid && (int'(arrive_floor) == f);
        if (sclr && m_pend[f]) m_ack = 1;
        m_pend[f] = (m_pend[f] || rise || sreq) && !sclr;
      end
      m_ready = 1;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NF-1:0] ev;
      int cnt;
      cnt = 0;
      for (int f = 0; f < NF; f++) begin
        ev[f] = m_pend[f];
        cnt += int'(m_pend[f]);
      end
      check("model_status", 32'(queue_status), 32'(ev));
      check("model_count", 32'(req_count), 32'(cnt));
      check("model_empty", 32'(queue_empty), 32'(cnt == 0));
      check("model_ready", 32'(req_ready), 32'(m_ready));
      check("model_err", 32'(req_err), 32'(m_err));
      check("model_ack", 32'(service_ack), 32'(m_ack));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    #1 chk_en = 1;
    cyc(); cyc();
    check("rst_status", 32'(queue_status), 0);
    check("rst_empty", 32'(queue_empty), 1);
    check("rst_count", 32'(req_count), 0);
    check("rst_ready", 32'(req_ready), 0);
    reset = 0;
    cyc();
    check("ready_after", 32'(req_ready), 1);
    // Port requests 4, 1, 6
    req_valid = 1; req_floor = 3'd4; cyc();
    req_floor = 3'd1; cyc();
    req_floor = 3'd6; cyc();
    check("req_vec", 32'(queue_status), 32'b1010010);
    check("req_cnt", 32'(req_count), 3);
    check("req_nempty", 32'(queue_empty), 0);
    // Out-of-range request
    req_floor = 3'd7; cyc();
    check("err_pulse", 32'(req_err), 1);
    check("err_vec", 32'(queue_status), 32'b1010010);
    req_valid = 0; cyc();
    check("err_clear", 32'(req_err), 0);
    // Held button on floor 2
    btn[2] = 1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i == BTN_LAT - 1) check("btn_early", 32'(queue_status[2]), 0);
      if (i == BTN_LAT)     check("btn_set", 32'(queue_status[2]), 1);
    end
    btn[2] = 0; cyc();
    check("btn_cnt", 32'(req_count), 4);
`ifdef REQ_DEBOUNCE_EN
    btn[5] = 1; cyc(); cyc(); btn[5] = 0;
    repeat (10) cyc();
    check("glitch", 32'(queue_status[5]), 0);
`endif
    // Arrivals
    arrive_valid = 1; arrive_floor = 3'd4; cyc();
    check("arr4_ack", 32'(service_ack), 1);
    check("arr4_bit", 32'(queue_status[4]), 0);
    check("arr4_cnt", 32'(req_count), 3);
    arrive_floor = 3'd0; cyc();
    check("arr0_ack", 32'(service_ack), 0);
    arrive_floor = 3'd7; cyc();
    check("arr7_ack", 32'(service_ack), 0);
    check("arr7_vec", 32'(queue_status), 32'b1000110);
    // Same-cycle request and arrival on floor 3, bit clear then set
    req_valid = 1; req_floor = 3'd3; arrive_floor = 3'd3; cyc();
    check("same_bit0", 32'(queue_status[3]), 0);
    check("same_ack0", 32'(service_ack), 0);
    arrive_valid = 0; cyc();
    check("pend3", 32'(queue_status[3]), 1);
    arrive_valid = 1; cyc();
    check("same_bit1", 32'(queue_status[3]), 0);
    check("same_ack1", 32'(service_ack), 1);
    arrive_valid = 0;
    // Fill every floor
    for (int f = 0; f < NF; f++) begin
      req_floor = FW'(f); cyc();
    end
    req_valid = 0; cyc();
    check("full_vec", 32'(queue_status), 32'h7f);
    check("full_cnt", 32'(req_count), 7);
    // Reset with everything pending and strobes active, button held through
    reset = 1; req_valid = 1; req_floor = 3'd7; arrive_valid = 1; arrive_floor = 3'd1;
    btn[3] = 1; cyc();
    check("mid_rst_vec", 32'(queue_status), 0);
    check("mid_rst_cnt", 32'(req_count), 0);
    check("mid_rst_empty", 32'(queue_empty), 1);
    check("mid_rst_ack", 32'(service_ack), 0);
    check("mid_rst_err", 32'(req_err), 0);
    check("mid_rst_rdy", 32'(req_ready), 0);
    reset = 0; req_valid = 0; arrive_valid = 0;
    for (int i = 1; i <= BTN_LAT + 2; i++) begin
      cyc();
      if (i == BTN_LAT) check("held_rst_btn", 32'(queue_status), 32'b0001000);
    end
    btn[3] = 0;
    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
